req_arbiter: RTL
================

# req_arbiter

Round-robin arbiter sharing the 4-to-2 encoder / 2-to-4 decoder path among four requesters. Each cycle it picks one active requester. It publishes that requester both as a one-hot grant (decoder form) and as a 2-bit index (encoder form), so the two views are always consistent. It sits in front of the shared resource, and requesters hold `req` high for as long as they need the resource.

## Interface
- `NREQ`, default 4: number of requesters; fixed at 4, power of two.
- `IDX_W`, default 2: index width, log2(NREQ).
- `HOLD_MAX`, default 8: maximum consecutive cycles one requester may hold the grant while others wait. Only used with `ARB_TIMEOUT_EN`. Legal range is 1..255.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `req`, input, NREQ: request vector; bit i high means requester i wants the resource.
- `grant_onehot`, output, NREQ: registered one-hot grant; all zero when idle.
- `grant_idx`, output, IDX_W: registered index of the current owner; 0 when idle.
- `grant_valid`, output, 1: high while a grant is held.
- `expired`, output, 1: one-cycle pulse when a grant is revoked by timeout. Tied to 0 without `ARB_TIMEOUT_EN`.

## Operation
- States:
  - `IDLE`: no owner.
  - `GRANT`: owner = `grant_idx`.
- Priority pointer `ptr` (IDX_W bits) is the highest-priority requester. The search order is ptr, ptr+1, ... mod NREQ, wrapping 3 to 0.
- `IDLE`:
  - if `req` is nonzero, grant the first set bit in rotated order from `ptr` and go to `GRANT`;
  - otherwise stay in `IDLE`.
- `GRANT`, owner o:
  - If `req[o]` = 1 and no timeout, keep the grant.
  - If `req[o]` = 0: set ptr = o+1, then re-arbitrate among the remaining requests on the same edge. This is a zero-bubble handover. Go to `IDLE` if none remain.
- Every new grant sets the hold counter to 0 and loads ptr = (new owner + 1) mod NREQ.
- Invariants, checked every cycle:
  - `grant_onehot` == decode(`grant_idx`) when `grant_valid` = 1, else 0.
  - `grant_valid` == |`grant_onehot`.
  - At most one bit of `grant_onehot` is set.
- Simultaneous requests: resolved purely by rotated order. A requester arriving on the same edge as the owner's release competes normally.
- Reset values: `grant_onehot` = 0, `grant_idx` = 0, `grant_valid` = 0, `expired` = 0, ptr = 0, hold counter = 0, state = `IDLE`.

## Timing
- `req` is sampled on the rising edge; the grant is visible after that edge. Latency from `req` to grant is 1 cycle.
- Release latency: the owner drops `req` in cycle n, and the next owner is granted at the end of cycle n. No idle cycle is inserted when another request is pending.
- Requesters must keep `req` high until granted. Dropping `req` before the grant simply withdraws the request; no state is kept per requester.
- `rst_n` low clears all outputs immediately, without a clock edge. Deassertion is synchronized externally. The first arbitration happens on the first rising edge after `rst_n` goes high.
- Reset mid-grant drops the grant with no handshake. Requesters must tolerate losing the grant.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - The hold counter increments every cycle in `GRANT`.
  - When counter == HOLD_MAX-1 and any other `req` bit is set, the next edge revokes the grant, re-arbitrates from ptr = o+1, and pulses `expired` for one cycle.
  - If no other requester is waiting, the counter saturates at HOLD_MAX-1 and the owner keeps the grant. It is revoked on the first edge where another request appears.
- `ARB_TIMEOUT_EN` undefined:
  - No hold counter, and `HOLD_MAX` is ignored.
  - `expired` is constant 0.
  - The owner holds the grant for as long as its `req` stays high.

## Structure
- Package `arb_pkg` holds: `NREQ`, `IDX_W`, the state enum type (`IDLE`, `GRANT`), and a `rotate_pick` function prototype comment.
- One sub-module, `rr_pick`, is purely combinational:
  - inputs: `req` (masked to exclude the current owner when needed) and `ptr`;
  - outputs: `found`, `idx`.
  - It rotates by ptr, priority-encodes, and un-rotates.
- The top level holds the FSM, ptr, hold counter and output registers. The one-hot output is derived from the index through a 2-to-4 decode before being registered.

## Test plan
- Reset: hold `rst_n` = 0 with `req` = 1111 → all outputs 0. Release reset, with ptr = 0 → after one edge `grant_onehot` = 0001, `grant_idx` = 0.
- Handover: `req` = 0101 → grant idx 0. Drop bit 0 (`req` = 0100) → on the next edge `grant_onehot` = 0100, idx 2, with no idle cycle between grants.
- Wrap: owner 3 (ptr = 0 after the grant), `req` = 1001. Drop bit 3 → grant idx 0. Then drop bit 0 with `req` = 0000 → `grant_valid` = 0 and state `IDLE`.
- Timeout, `ARB_TIMEOUT_EN` with HOLD_MAX = 4, constant `req` = 0011 → idx 0 for 4 cycles, `expired` pulses once, idx 1 for 4 cycles, then idx 0 again.
- No contention, `ARB_TIMEOUT_EN` with HOLD_MAX = 4, `req` = 0010 for 20 cycles → idx 1 throughout, `expired` never pulses. Raise bit 0 → grant moves to idx 0 on the next edge.
- Async reset mid-grant: owner idx 2, drive `rst_n` low between edges → outputs go to 0 before the next edge. Release reset with `req` = 1000 → idx 3 after one edge.

Source files
------------

// File: rtl/req_arbiter_pkg.sv
// Shared types and constants for the four-way round-robin request arbiter.
// Optional feature macro used by this slice: ARB_TIMEOUT_EN (grant hold timeout).
package arb_pkg;

  localparam int NREQ  = 4;
  localparam int IDX_W = 2;

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  // rotate_pick(req, ptr) -> {found, idx}: first set bit of req searching
  // ptr, ptr+1, ... mod NREQ. Realised in hardware by the rr_pick module.

  // 2-to-4 decode of an owner index into its one-hot grant.
  function automatic logic [NREQ-1:0] decode_idx(input logic [IDX_W-1:0] idx);
    return NREQ'(1) << idx;
  endfunction

endpackage

// File: rtl/req_arbiter_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
// Optional feature macro: ARB_TIMEOUT_EN (drives expired when enabled).
interface req_arbiter_if;
  import arb_pkg::*;

  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  grant_onehot;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_valid;
  logic             expired;

  modport master (
    output req,
    input  grant_onehot, grant_idx, grant_valid, expired
  );

  modport slave (
    input  req,
    output grant_onehot, grant_idx, grant_valid, expired
  );

endinterface

// File: rtl/req_arbiter_rr_pick.sv
// Combinational rotated priority pick: first set request at or after ptr.
// Independent of the ARB_TIMEOUT_EN macro.
module rr_pick
  import arb_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   rot;
  logic [IDX_W-1:0]  off;

  // Doubling the vector turns the wrap-around rotation into a plain shift.
  assign req_dbl = {req, req};
  assign rot     = NREQ'(req_dbl >> ptr);

  // NOTE: every variable written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    off = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
  end

  assign found = |req;
  assign idx   = ptr + off;

endmodule

// File: rtl/req_arbiter.sv
// Round-robin arbiter for four requesters with one-hot and index grant views.
// ARB_TIMEOUT_EN enables the HOLD_MAX grant timeout and the expired pulse.
module req_arbiter
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  req_arbiter_if.slave  bus
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [NREQ-1:0]  onehot_q, onehot_d;
  logic             valid_q, valid_d;
  logic             expired_q, expired_d;

  logic [NREQ-1:0]  pick_req;
  logic [IDX_W-1:0] pick_ptr, pick_idx;
  logic             pick_found;
  logic             owner_gone, timeout, revoke;

  // While granted, the owner is masked out and the search starts just past it.
  assign pick_req   = (state_q == GRANT) ? (bus.req & ~onehot_q) : bus.req;
  assign pick_ptr   = (state_q == GRANT) ? (idx_q + IDX_W'(1)) : ptr_q;
  assign owner_gone = (state_q == GRANT) && !bus.req[idx_q];

  rr_pick u_pick (
    .req   (pick_req),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
  logic [7:0] hold_q, hold_d;

  assign timeout = (state_q == GRANT) && (hold_q == HOLD_LAST) &&
                   |(bus.req & ~onehot_q);
`else
  logic unused_hold_max;
  assign unused_hold_max = ^HOLD_MAX;
  assign timeout         = 1'b0;
`endif

  assign revoke = owner_gone || timeout;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    expired_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
    hold_d    = (hold_q == HOLD_LAST) ? hold_q : hold_q + 8'd1;
`endif
    if (state_q == IDLE || revoke) begin
      expired_d = timeout;
      ptr_d     = pick_ptr;
      if (pick_found) begin
        state_d = GRANT;
        idx_d   = pick_idx;
        ptr_d   = pick_idx + IDX_W'(1);
`ifdef ARB_TIMEOUT_EN
        hold_d  = '0;
`endif
      end else begin
        state_d = IDLE;
        idx_d   = '0;
`ifdef ARB_TIMEOUT_EN
        hold_d  = '0;
`endif
      end
    end
    onehot_d = (state_d == GRANT) ? decode_idx(idx_d) : '0;
    valid_d  = (state_d == GRANT);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      ptr_q     <= '0;
      onehot_q  <= '0;
      valid_q   <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      onehot_q  <= onehot_d;
      valid_q   <= valid_d;
      expired_q <= expired_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_q <= '0;
    else        hold_q <= hold_d;
  end
`endif

  assign bus.grant_onehot = onehot_q;
  assign bus.grant_idx    = idx_q;
  assign bus.grant_valid  = valid_q;
  assign bus.expired      = expired_q;

endmodule
